// File: rtl/ltc2333_sdo_capture.sv
// LTC2333 SDO deserialiser: samples SDO on delayed SCKI rises, checks the channel
// sequence and queues 24-bit result words toward an AXI4-Stream master.
module ltc2333_sdo_capture #(
   parameter int FIFO_DEPTH   = 16,
   parameter int SAMPLE_DELAY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic [7:0]           active_channels,
   input  logic                 clear_status,
   input  logic                 cnv,
   input  logic                 scki,
   input  logic                 sdo,
   output logic [31:0]          m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 seq_error,
   output logic [CNT_WIDTH-1:0] overflow_count,
   output logic [CNT_WIDTH-1:0] abort_count,
   output logic [CNT_WIDTH-1:0] frame_count
);

   // state   | meaning
   // S_IDLE  | waiting for a cnv rise with a non-empty channel mask
   // S_ARMED | mask latched, waiting for the first scki rise
   // S_SHIFT | collecting SDO bits MSB first
   // S_PUSH  | word complete: enqueue, check chan_id, advance or finish frame

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (SAMPLE_DELAY > 0) ? SAMPLE_DELAY : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_PUSH} state_t;
   state_t state;

   logic          sdo_s1, sdo_s2, scki_d, cnv_d;
   logic [PW-1:0] rise_pipe;
   logic          scki_rise, cnv_rise, sample_pulse;
   logic [7:0]    mask_rem;
   logic [4:0]    bit_idx;
   logic [23:0]   shift_reg;
   logic [2:0]    exp_ch;
   logic          last_word, push_req, push_ok, pop, fifo_full;
   logic [31:0]   word_fmt;
   logic [32:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign scki_rise    = scki & ~scki_d;
   assign cnv_rise     = cnv & ~cnv_d;
   assign sample_pulse = (SAMPLE_DELAY == 0) ? scki_rise : rise_pipe[PW-1];

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         sdo_s1 <= 1'b0;
         sdo_s2 <= 1'b0;
         scki_d <= 1'b0;
         cnv_d  <= 1'b0;
      end else begin
         sdo_s1 <= sdo;
         sdo_s2 <= sdo_s1;
         scki_d <= scki;
         cnv_d  <= cnv;
      end
   end

   // Remaining mask holds the channels not yet received; its lowest set bit is the next one due.
   always_comb begin
      exp_ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_rem[i]) exp_ch = 3'(i);
      end
   end

   assign last_word = (mask_rem & (mask_rem - 8'd1)) == 8'd0;
   assign word_fmt  = {2'b00, shift_reg[2:0], shift_reg[5:3], 6'b000000, shift_reg[23:6]};
   assign push_req  = (state == S_PUSH) && enable;
   assign pop       = m_axis_tvalid && m_axis_tready;
   assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
   assign push_ok   = push_req && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state          <= S_IDLE;
         rise_pipe      <= '0;
         mask_rem       <= '0;
         bit_idx        <= '0;
         shift_reg      <= '0;
         seq_error      <= 1'b0;
         overflow_count <= '0;
         abort_count    <= '0;
         frame_count    <= '0;
      end else begin
         rise_pipe <= (rise_pipe << 1) | PW'(scki_rise);
         if (!enable) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cnv_rise && active_channels != 8'd0) begin
                     state     <= S_ARMED;
                     mask_rem  <= active_channels;
                     bit_idx   <= 5'd23;
                     rise_pipe <= '0;
                  end
               end
               S_ARMED, S_SHIFT: begin
                  if (cnv_rise) begin
                     if (abort_count != CNT_MAX) abort_count <= abort_count + 1'b1;
                     state     <= (active_channels != 8'd0) ? S_ARMED : S_IDLE;
                     mask_rem  <= active_channels;
                     bit_idx   <= 5'd23;
                     rise_pipe <= '0;
                  end else if (sample_pulse) begin
                     shift_reg <= {shift_reg[22:0], sdo_s2};
                     if (bit_idx == 5'd0) begin
                        state <= S_PUSH;
                     end else begin
                        bit_idx <= bit_idx - 5'd1;
                        state   <= S_SHIFT;
                     end
                  end else if (scki_rise) begin
                     state <= S_SHIFT;
                  end
               end
               S_PUSH: begin
                  if (exp_ch != shift_reg[5:3]) seq_error <= 1'b1;
                  if (!push_ok && overflow_count != CNT_MAX) overflow_count <= overflow_count + 1'b1;
                  if (last_word) frame_count <= frame_count + 1'b1;
                  bit_idx <= 5'd23;
                  // A cnv rise landing on the push cycle still keeps the completed word.
                  if (cnv_rise) begin
                     if (!last_word && abort_count != CNT_MAX) abort_count <= abort_count + 1'b1;
                     mask_rem  <= active_channels;
                     rise_pipe <= '0;
                     state     <= (active_channels != 8'd0) ? S_ARMED : S_IDLE;
                  end else begin
                     mask_rem <= mask_rem & (mask_rem - 8'd1);
                     state    <= last_word ? S_IDLE : S_SHIFT;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
         if (clear_status) begin
            seq_error      <= 1'b0;
            overflow_count <= '0;
            abort_count    <= '0;
            frame_count    <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {last_word, word_fmt};
   end

   assign m_axis_tvalid = count != '0;
   assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][31:0] : 32'd0;
   assign m_axis_tlast  = m_axis_tvalid & mem[rd_ptr][32];

endmodule

// File: tb/tb_ltc2333_sdo_capture.sv
// Directed bench for ltc2333_sdo_capture: one default instance plus four instances
// sweeping SAMPLE_DELAY 0..3, each fed SDO valid in a single-cycle window.
module tb_ltc2333_sdo_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        aresetn, enable, clear_status, cnv, scki, tready;
   logic [7:0]  active_channels;
   logic [3:0]  sdo_v;
   logic [31:0] tdata;
   logic        tvalid, tlast, seq_error;
   logic [15:0] overflow_count, abort_count, frame_count;

   logic [31:0] sw_tdata [4];
   logic        sw_tvalid [4];
   logic        sw_tlast [4];
   logic        sw_seq [4];
   logic [15:0] sw_ovf [4];
   logic [15:0] sw_abt [4];
   logic [15:0] sw_frm [4];

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] cap_data [256];
   logic        cap_last [256];
   int          cap_n = 0;
   logic [31:0] sw_data [4][256];
   logic        sw_last [4][256];
   int          sw_n [4] = '{0, 0, 0, 0};
   logic [23:0] wtab [8];

   ltc2333_sdo_capture #(.FIFO_DEPTH(16), .SAMPLE_DELAY(1), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .aresetn(aresetn), .enable(enable), .active_channels(active_channels),
      .clear_status(clear_status), .cnv(cnv), .scki(scki), .sdo(sdo_v[1]),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .seq_error(seq_error), .overflow_count(overflow_count),
      .abort_count(abort_count), .frame_count(frame_count)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      ltc2333_sdo_capture #(.FIFO_DEPTH(16), .SAMPLE_DELAY(g), .CNT_WIDTH(16)) u_dut (
         .clk(clk), .aresetn(aresetn), .enable(enable), .active_channels(active_channels),
         .clear_status(clear_status), .cnv(cnv), .scki(scki), .sdo(sdo_v[g]),
         .m_axis_tdata(sw_tdata[g]), .m_axis_tvalid(sw_tvalid[g]), .m_axis_tready(1'b1),
         .m_axis_tlast(sw_tlast[g]), .seq_error(sw_seq[g]), .overflow_count(sw_ovf[g]),
         .abort_count(sw_abt[g]), .frame_count(sw_frm[g])
      );
   end

   // Beats are logged mid-low-phase; the handshake completes on the following rising edge.
   always @(negedge clk) begin
      #2;
      if (tvalid && tready) begin
         if (cap_n < 256) begin
            cap_data[cap_n] = tdata;
            cap_last[cap_n] = tlast;
         end
         cap_n++;
      end
      for (int g = 0; g < 4; g++) begin
         if (sw_tvalid[g]) begin
            if (sw_n[g] < 256) begin
               sw_data[g][sw_n[g]] = sw_tdata[g];
               sw_last[g][sw_n[g]] = sw_tlast[g];
            end
            sw_n[g]++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] mk_word(input logic [17:0] res, input logic [2:0] ch,
                                           input logic [2:0] ss);
      return {res, ch, ss};
   endfunction

   function automatic logic [31:0] mk_beat(input logic [17:0] res, input logic [2:0] ch,
                                           input logic [2:0] ss);
      return {2'b00, ss, ch, 6'b000000, res};
   endfunction

   function automatic logic [17:0] res_of(input int i);
      return 18'h30000 + 18'(i * 291);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Each bit: 8 clk periods, scki high for the last 4. Instance g sees the true bit only
   // in the cycle that its synchroniser delivers to the sample point SAMPLE_DELAY after the rise.
   task automatic drive_bits(input logic [23:0] w, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            scki = (c >= 4);
            for (int g = 0; g < 4; g++) sdo_v[g] = (c == 2 + g) ? w[23-k] : ~w[23-k];
         end
      end
   endtask

   task automatic start_frame(input logic [7:0] mask);
      @(negedge clk);
      active_channels = mask;
      scki = 1'b0;
      cnv = 1'b1;
      @(negedge clk);
      cnv = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] mask, input int n);
      start_frame(mask);
      for (int i = 0; i < n; i++) drive_bits(wtab[i], 24);
      idle(12);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int sb [4];
      aresetn = 1'b0; enable = 1'b0; clear_status = 1'b0; cnv = 1'b0; scki = 1'b0;
      tready = 1'b1; active_channels = 8'h00; sdo_v = 4'h0;
      idle(3);
      chk("rst_tvalid", 32'(tvalid), 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tlast", 32'(tlast), 0);
      chk("rst_seq_error", 32'(seq_error), 0);
      chk("rst_overflow", 32'(overflow_count), 0);
      chk("rst_abort", 32'(abort_count), 0);
      chk("rst_frames", 32'(frame_count), 0);
      @(negedge clk);
      aresetn = 1'b1;
      enable = 1'b1;
      idle(2);

      // Two-channel frame with known tdata layout
      wtab[0] = mk_word(18'h2AAAA, 3'd0, 3'd7);
      wtab[1] = mk_word(18'h15555, 3'd2, 3'd7);
      b = cap_n;
      start_frame(8'h05);
      drive_bits(wtab[0], 24);
      #1 chk("t1_first_latency", 32'(tvalid), 1);
      drive_bits(wtab[1], 24);
      idle(12);
      chk("t1_beats", cap_n - b, 2);
      chk("t1_beat0", cap_data[b], 32'h3802AAAA);
      chk("t1_last0", 32'(cap_last[b]), 0);
      chk("t1_beat1", cap_data[b+1], 32'h3A015555);
      chk("t1_last1", 32'(cap_last[b+1]), 1);
      chk("t1_frames", 32'(frame_count), 1);
      chk("t1_seq_error", 32'(seq_error), 0);

      // Full mask with channel 3 reporting chan_id 4
      for (int i = 0; i < 8; i++) wtab[i] = mk_word(res_of(i), 3'(i), 3'(7 - i));
      wtab[3] = mk_word(res_of(3), 3'd4, 3'd4);
      b = cap_n;
      send_frame(8'hFF, 8);
      chk("t2_beats", cap_n - b, 8);
      chk("t2_seq_error", 32'(seq_error), 1);
      chk("t2_beat3", cap_data[b+3], mk_beat(res_of(3), 3'd4, 3'd4));
      chk("t2_beat7", cap_data[b+7], mk_beat(res_of(7), 3'd7, 3'd0));
      chk("t2_last6", 32'(cap_last[b+6]), 0);
      chk("t2_last7", 32'(cap_last[b+7]), 1);
      chk("t2_frames", 32'(frame_count), 2);
      pulse_clear();
      chk("t2_seq_cleared", 32'(seq_error), 0);
      chk("t2_frames_cleared", 32'(frame_count), 0);

      // Stalled consumer: three 8-word frames into a 16-entry FIFO
      wtab[3] = mk_word(res_of(3), 3'd3, 3'd4);
      @(negedge clk);
      tready = 1'b0;
      send_frame(8'hFF, 8);
      send_frame(8'hFF, 8);
      send_frame(8'hFF, 8);
      chk("t3_tvalid", 32'(tvalid), 1);
      chk("t3_head_tdata", tdata, mk_beat(res_of(0), 3'd0, 3'd7));
      chk("t3_head_tlast", 32'(tlast), 0);
      chk("t3_overflow", 32'(overflow_count), 8);
      chk("t3_frames", 32'(frame_count), 3);
      chk("t3_seq_error", 32'(seq_error), 0);
      b = cap_n;
      @(negedge clk);
      tready = 1'b1;
      idle(24);
      chk("t3_drained", cap_n - b, 16);
      chk("t3_last7", 32'(cap_last[b+7]), 1);
      chk("t3_last15", 32'(cap_last[b+15]), 1);
      chk("t3_beat8", cap_data[b+8], mk_beat(res_of(0), 3'd0, 3'd7));
      chk("t3_empty", 32'(tvalid), 0);

      // Frame aborted 10 bits into word 2, then a complete frame
      pulse_clear();
      b = cap_n;
      start_frame(8'h0F);
      drive_bits(wtab[0], 24);
      drive_bits(wtab[1], 10);
      send_frame(8'h0F, 4);
      chk("t4_abort", 32'(abort_count), 1);
      chk("t4_beats", cap_n - b, 5);
      chk("t4_beat0", cap_data[b], mk_beat(res_of(0), 3'd0, 3'd7));
      chk("t4_last0", 32'(cap_last[b]), 0);
      chk("t4_last3", 32'(cap_last[b+3]), 0);
      chk("t4_last4", 32'(cap_last[b+4]), 1);
      chk("t4_beat4", cap_data[b+4], mk_beat(res_of(3), 3'd3, 3'd4));
      chk("t4_frames", 32'(frame_count), 1);

      // Reset mid-shift with three words queued
      @(negedge clk);
      tready = 1'b0;
      start_frame(8'hFF);
      for (int i = 0; i < 3; i++) drive_bits(wtab[i], 24);
      drive_bits(wtab[3], 5);
      #1 chk("t5_queued", 32'(tvalid), 1);
      @(negedge clk);
      aresetn = 1'b0;
      @(negedge clk);
      chk("t5_tvalid", 32'(tvalid), 0);
      chk("t5_tdata", tdata, 0);
      chk("t5_tlast", 32'(tlast), 0);
      chk("t5_abort", 32'(abort_count), 0);
      chk("t5_frames", 32'(frame_count), 0);
      chk("t5_overflow", 32'(overflow_count), 0);
      idle(2);
      aresetn = 1'b1;
      drive_bits(wtab[0], 24);
      idle(4);
      chk("t5_idle_no_capture", 32'(tvalid), 0);
      @(negedge clk);
      tready = 1'b1;

      // SAMPLE_DELAY sweep
      pulse_clear();
      for (int g = 0; g < 4; g++) sb[g] = sw_n[g];
      wtab[0] = mk_word(18'h2AAAA, 3'd0, 3'd7);
      wtab[1] = mk_word(18'h15555, 3'd2, 3'd7);
      send_frame(8'h05, 2);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("t6_d%0d_beats", g), sw_n[g] - sb[g], 2);
         chk($sformatf("t6_d%0d_beat0", g), sw_data[g][sb[g]], 32'h3802AAAA);
         chk($sformatf("t6_d%0d_beat1", g), sw_data[g][sb[g]+1], 32'h3A015555);
         chk($sformatf("t6_d%0d_last1", g), 32'(sw_last[g][sb[g]+1]), 1);
         chk($sformatf("t6_d%0d_frames", g), 32'(sw_frm[g]), 1);
         chk($sformatf("t6_d%0d_abort", g), 32'(sw_abt[g]), 0);
         chk($sformatf("t6_d%0d_overflow", g), 32'(sw_ovf[g]), 0);
         chk($sformatf("t6_d%0d_seq", g), 32'(sw_seq[g]), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
